// File: rtl/mem_stage_if.sv
// Y86 memory-stage bundle: upstream pipe inputs, data-memory port and write-back payload.
// slave = the memory stage itself, master = whoever drives it (execute/memory/write-back side).
interface mem_stage_if #(
  parameter int DW = 32
);
  logic          valid_i;
  logic [7:0]    icode_i;
  logic          cnd_i;
  logic [DW-1:0] valE_i;
  logic [DW-1:0] valA_i;
  logic [DW-1:0] valP_i;
  logic [7:0]    dstE_i;
  logic [7:0]    dstM_i;
  logic          stall_o;

  logic          dmem_req_o;
  logic          dmem_we_o;
  logic [DW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic [DW-1:0] dmem_rdata_i;
  logic          dmem_ack_i;
  logic          dmem_err_i;

  logic          valid_o;
  logic [7:0]    icode_o;
  logic [DW-1:0] valE_o;
  logic [DW-1:0] valM_o;
  logic [7:0]    dstE_o;
  logic [7:0]    dstM_o;
  logic [2:0]    stat_o;

  modport slave (
    input  valid_i, icode_i, cnd_i, valE_i, valA_i, valP_i, dstE_i, dstM_i,
    output stall_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_rdata_i, dmem_ack_i, dmem_err_i,
    output valid_o, icode_o, valE_o, valM_o, dstE_o, dstM_o, stat_o
  );

  modport master (
    output valid_i, icode_i, cnd_i, valE_i, valA_i, valP_i, dstE_i, dstM_i,
    input  stall_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_rdata_i, dmem_ack_i, dmem_err_i,
    input  valid_o, icode_o, valE_o, valM_o, dstE_o, dstM_o, stat_o
  );
endinterface

// File: rtl/mem_stage.sv
// Y86 memory stage: one data-memory access per instruction, stalls upstream while busy.
// Optional MEM_ALIGN_CHECK_EN: misaligned memory ops fault with ADR instead of issuing a request.
module mem_stage #(
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [7:0] IC_HALT   = 8'h00;
  localparam logic [7:0] IC_NOP    = 8'h01;
  localparam logic [7:0] IC_CMOVXX = 8'h02;
  localparam logic [7:0] IC_RMMOVL = 8'h04;
  localparam logic [7:0] IC_MRMOVL = 8'h05;
  localparam logic [7:0] IC_CALL   = 8'h08;
  localparam logic [7:0] IC_RET    = 8'h09;
  localparam logic [7:0] IC_PUSHL  = 8'h0A;
  localparam logic [7:0] IC_POPL   = 8'h0B;

  localparam logic [7:0] REG_NONE = 8'h0F;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  function automatic logic f_is_read(input logic [7:0] icode);
    f_is_read = (icode == IC_MRMOVL) || (icode == IC_POPL) || (icode == IC_RET);
  endfunction

  function automatic logic f_is_write(input logic [7:0] icode);
    f_is_write = (icode == IC_RMMOVL) || (icode == IC_PUSHL) || (icode == IC_CALL);
  endfunction

  function automatic logic f_is_invalid(input logic [7:0] icode);
    f_is_invalid = (icode > IC_POPL);
  endfunction

  logic [1:0]    r_state;
  logic          r_valid;
  logic [7:0]    r_icode;
  logic [DW-1:0] r_valE;
  logic [DW-1:0] r_valM;
  logic [7:0]    r_dstE;
  logic [7:0]    r_dstM;
  logic [2:0]    r_stat;
  logic          r_req;
  logic          r_we;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_is_read;

  logic          w_accept;
  logic          w_is_read;
  logic          w_is_write;
  logic          w_is_mem;
  logic          w_invalid;
  logic          w_misalign;
  logic [DW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [7:0]    w_dstE;

  // Decode the instruction offered by execute into access type, address, data and dstE.
  always_comb begin
    w_accept   = bus.valid_i && (r_state == S_IDLE);
    w_is_read  = f_is_read(bus.icode_i);
    w_is_write = f_is_write(bus.icode_i);
    w_is_mem   = w_is_read || w_is_write;
    w_invalid  = f_is_invalid(bus.icode_i);
    if ((bus.icode_i == IC_POPL) || (bus.icode_i == IC_RET)) begin
      w_addr = bus.valA_i;
    end else begin
      w_addr = bus.valE_i;
    end
    if (bus.icode_i == IC_CALL) begin
      w_wdata = bus.valP_i;
    end else begin
      w_wdata = bus.valA_i;
    end
    if ((bus.icode_i == IC_CMOVXX) && !bus.cnd_i) begin
      w_dstE = REG_NONE;
    end else begin
      w_dstE = bus.dstE_i;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_is_mem && (w_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Stage FSM plus the write-back payload and data-memory request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_icode   <= IC_NOP;
      r_valE    <= '0;
      r_valM    <= '0;
      r_dstE    <= REG_NONE;
      r_dstM    <= REG_NONE;
      r_stat    <= STAT_AOK;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_read <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_icode <= bus.icode_i;
            r_valE  <= bus.valE_i;
            r_dstE  <= w_dstE;
            r_dstM  <= bus.dstM_i;
            if (w_invalid) begin
              r_valid <= 1'b1;
              r_stat  <= STAT_INS;
              r_state <= S_HALTED;
            end else if (bus.icode_i == IC_HALT) begin
              r_valid <= 1'b1;
              r_stat  <= STAT_HLT;
              r_state <= S_HALTED;
            end else if (w_is_mem && w_misalign) begin
              r_valid <= 1'b1;
              r_stat  <= STAT_ADR;
              r_dstE  <= REG_NONE;
              r_dstM  <= REG_NONE;
              r_state <= S_HALTED;
            end else if (w_is_mem) begin
              r_valid   <= 1'b0;
              r_req     <= 1'b1;
              r_we      <= w_is_write;
              r_addr    <= w_addr;
              r_wdata   <= w_wdata;
              r_is_read <= w_is_read;
              r_state   <= S_BUSY;
            end else begin
              r_valid <= 1'b1;
              r_stat  <= STAT_AOK;
            end
          end else begin
            r_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          if (bus.dmem_ack_i) begin
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            if (bus.dmem_err_i) begin
              r_stat  <= STAT_ADR;
              r_dstE  <= REG_NONE;
              r_dstM  <= REG_NONE;
              r_state <= S_HALTED;
            end else begin
              r_stat  <= STAT_AOK;
              r_state <= S_IDLE;
              if (r_is_read) begin
                r_valM <= bus.dmem_rdata_i;
              end else begin
                r_valM <= r_valM;
              end
            end
          end else begin
            r_valid <= 1'b0;
          end
        end
        S_HALTED: begin
          r_valid <= 1'b0;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
        default: begin
          r_valid <= 1'b0;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall_o      = (r_state != S_IDLE);
  assign bus.dmem_req_o   = r_req;
  assign bus.dmem_we_o    = r_we;
  assign bus.dmem_addr_o  = r_addr;
  assign bus.dmem_wdata_o = r_wdata;
  assign bus.valid_o      = r_valid;
  assign bus.icode_o      = r_icode;
  assign bus.valE_o       = r_valE;
  assign bus.valM_o       = r_valM;
  assign bus.dstE_o       = r_dstE;
  assign bus.dstM_o       = r_dstM;
  assign bus.stat_o       = r_stat;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back payloads are queued at issue and
// popped whenever valid_o is seen; memory responses are played by the issuing task.
module tb_mem_stage;

  typedef struct {
    logic [7:0]  icode;
    logic [31:0] valE;
    logic [31:0] valM;
    logic [7:0]  dstE;
    logic [7:0]  dstM;
    logic [2:0]  stat;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    n_vec = 0;
  int    n_err = 0;
  exp_t  q[$];
  exp_t  mon_e;
  logic [31:0] m_valM = 32'd0;

  mem_stage_if #(.DW(32)) bus_if ();

  mem_stage #(.DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write-back monitor: every valid_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && bus_if.valid_o) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", {31'd0, bus_if.valid_o}, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("wb_icode", {24'd0, bus_if.icode_o}, {24'd0, mon_e.icode});
        chk("wb_valE", bus_if.valE_o, mon_e.valE);
        chk("wb_valM", bus_if.valM_o, mon_e.valM);
        chk("wb_dstE", {24'd0, bus_if.dstE_o}, {24'd0, mon_e.dstE});
        chk("wb_dstM", {24'd0, bus_if.dstM_o}, {24'd0, mon_e.dstM});
        chk("wb_stat", {29'd0, bus_if.stat_o}, {29'd0, mon_e.stat});
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_valid", {31'd0, bus_if.valid_o}, 32'd0);
    chk("rst_req", {31'd0, bus_if.dmem_req_o}, 32'd0);
    chk("rst_we", {31'd0, bus_if.dmem_we_o}, 32'd0);
    chk("rst_stall", {31'd0, bus_if.stall_o}, 32'd0);
    chk("rst_valE", bus_if.valE_o, 32'd0);
    chk("rst_valM", bus_if.valM_o, 32'd0);
    chk("rst_addr", bus_if.dmem_addr_o, 32'd0);
    chk("rst_wdata", bus_if.dmem_wdata_o, 32'd0);
    chk("rst_icode", {24'd0, bus_if.icode_o}, 32'h01);
    chk("rst_dstE", {24'd0, bus_if.dstE_o}, 32'h0F);
    chk("rst_dstM", {24'd0, bus_if.dstM_o}, 32'h0F);
    chk("rst_stat", {29'd0, bus_if.stat_o}, 32'd1);
  endtask

  // Called at posedge+1; reset is asserted between edges to exercise the async path.
  task automatic do_reset(input int exp_pending);
    @(negedge clk);
    #1;
    chk("pending_before_reset", q.size(), exp_pending);
    rst = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, bus_if.dmem_req_o}, 32'd0);
    q.delete();
    m_valM = 32'd0;
    @(posedge clk);
    #1;
    chk_reset_vals();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction; acks = request cycles before completion (0 = never answer).
  task automatic send(input logic [7:0] ic, input logic cnd, input logic [31:0] ve,
                      input logic [31:0] va, input logic [31:0] vp, input logic [7:0] de,
                      input logic [7:0] dm, input int acks, input logic [31:0] rd,
                      input logic err);
    logic rdop, wrop, mem, mis;
    logic [31:0] ea, ew;
    exp_t e;
    int t;
    rdop = (ic == 8'h05) || (ic == 8'h0B) || (ic == 8'h09);
    wrop = (ic == 8'h04) || (ic == 8'h0A) || (ic == 8'h08);
    mem  = rdop || wrop;
    ea   = ((ic == 8'h0B) || (ic == 8'h09)) ? va : ve;
    ew   = (ic == 8'h08) ? vp : va;
    mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis  = mem && (ea[1:0] != 2'b00);
`endif
    t = 0;
    while (bus_if.stall_o && (t < 20)) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("stall_before_issue", {31'd0, bus_if.stall_o}, 32'd0);

    e.icode = ic;
    e.valE  = ve;
    e.dstE  = ((ic == 8'h02) && !cnd) ? 8'h0F : de;
    e.dstM  = dm;
    if (ic > 8'h0B)                  e.stat = 3'd4;
    else if (ic == 8'h00)            e.stat = 3'd2;
    else if (mem && (mis || err))    e.stat = 3'd3;
    else                             e.stat = 3'd1;
    if (e.stat == 3'd3) begin
      e.dstE = 8'h0F;
      e.dstM = 8'h0F;
    end
    if (rdop && !mis && !err && (acks > 0)) m_valM = rd;
    e.valM = m_valM;
    q.push_back(e);

    bus_if.valid_i = 1'b1;
    bus_if.icode_i = ic;
    bus_if.cnd_i   = cnd;
    bus_if.valE_i  = ve;
    bus_if.valA_i  = va;
    bus_if.valP_i  = vp;
    bus_if.dstE_i  = de;
    bus_if.dstM_i  = dm;
    @(posedge clk);
    #1;
    bus_if.valid_i = 1'b0;

    if (mem && !mis) begin
      chk("req_addr", bus_if.dmem_addr_o, ea);
      chk("req_we", {31'd0, bus_if.dmem_we_o}, {31'd0, wrop});
      if (wrop) chk("req_wdata", bus_if.dmem_wdata_o, ew);
      for (int k = 1; k <= acks; k++) begin
        chk("req_held", {31'd0, bus_if.dmem_req_o}, 32'd1);
        chk("stall_busy", {31'd0, bus_if.stall_o}, 32'd1);
        if (k == acks) begin
          bus_if.dmem_ack_i   = 1'b1;
          bus_if.dmem_rdata_i = rd;
          bus_if.dmem_err_i   = err;
        end
        @(posedge clk);
        #1;
      end
      if (acks > 0) begin
        bus_if.dmem_ack_i   = 1'b0;
        bus_if.dmem_err_i   = 1'b0;
        bus_if.dmem_rdata_i = 32'd0;
        chk("req_drop", {31'd0, bus_if.dmem_req_o}, 32'd0);
        chk("stall_after_ack", {31'd0, bus_if.stall_o}, {31'd0, err});
      end else begin
        chk("req_outstanding", {31'd0, bus_if.dmem_req_o}, 32'd1);
      end
    end else if (mem) begin
      chk("misalign_no_req", {31'd0, bus_if.dmem_req_o}, 32'd0);
    end
  endtask

  initial begin
    bus_if.valid_i      = 1'b0;
    bus_if.icode_i      = 8'h01;
    bus_if.cnd_i        = 1'b0;
    bus_if.valE_i       = 32'd0;
    bus_if.valA_i       = 32'd0;
    bus_if.valP_i       = 32'd0;
    bus_if.dstE_i       = 8'h0F;
    bus_if.dstM_i       = 8'h0F;
    bus_if.dmem_rdata_i = 32'd0;
    bus_if.dmem_ack_i   = 1'b0;
    bus_if.dmem_err_i   = 1'b0;
    @(posedge clk);
    #1;
    do_reset(0);

    // Back-to-back non-memory ops: one valid pulse per cycle, no stall.
    send(8'h06, 1'b1, 32'h5,  32'h0, 32'h0, 8'h03, 8'h0F, 0, 32'h0, 1'b0);
    chk("b2b_valid0", {31'd0, bus_if.valid_o}, 32'd1);
    send(8'h03, 1'b1, 32'h10, 32'h0, 32'h0, 8'h00, 8'h0F, 0, 32'h0, 1'b0);
    chk("b2b_valid1", {31'd0, bus_if.valid_o}, 32'd1);
    chk("b2b_stall", {31'd0, bus_if.stall_o}, 32'd0);

    // Loads/stores with various ack latencies.
    send(8'h05, 1'b1, 32'h100, 32'h0, 32'h0, 8'h0F, 8'h02, 3, 32'hDEADBEEF, 1'b0);
    send(8'h08, 1'b1, 32'h7C, 32'h0, 32'h2A, 8'h04, 8'h0F, 1, 32'h0, 1'b0);
    send(8'h0B, 1'b1, 32'h80, 32'h7C, 32'h0, 8'h04, 8'h03, 1, 32'h55, 1'b0);
    send(8'h0A, 1'b1, 32'h78, 32'h99, 32'h0, 8'h04, 8'h0F, 2, 32'h0, 1'b0);

    // An ack outside BUSY must be ignored.
    bus_if.dmem_ack_i   = 1'b1;
    bus_if.dmem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    bus_if.dmem_ack_i   = 1'b0;
    bus_if.dmem_rdata_i = 32'd0;
    chk("stray_ack_valid", {31'd0, bus_if.valid_o}, 32'd0);
    chk("stray_ack_valM", bus_if.valM_o, m_valM);
    chk("stray_ack_stall", {31'd0, bus_if.stall_o}, 32'd0);

    // Conditional move not taken / taken.
    send(8'h02, 1'b0, 32'h9, 32'h9, 32'h0, 8'h01, 8'h0F, 0, 32'h0, 1'b0);
    send(8'h02, 1'b1, 32'hA, 32'hA, 32'h0, 8'h01, 8'h0F, 0, 32'h0, 1'b0);

    // Misaligned store: faults with the alignment check, issues as-is without it.
    send(8'h04, 1'b1, 32'h102, 32'h1234, 32'h0, 8'h0F, 8'h0F, 1, 32'h0, 1'b0);
    do_reset(0);

    // Reset while a load is outstanding abandons it.
    send(8'h05, 1'b1, 32'h200, 32'h0, 32'h0, 8'h0F, 8'h05, 0, 32'h0, 1'b0);
    do_reset(1);

    // Invalid icode halts the stage; stall stays high and further inputs are ignored.
    send(8'h0C, 1'b1, 32'h3, 32'h0, 32'h0, 8'h02, 8'h0F, 0, 32'h0, 1'b0);
    bus_if.valid_i = 1'b1;
    bus_if.icode_i = 8'h06;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("halted_stall", {31'd0, bus_if.stall_o}, 32'd1);
      chk("halted_req", {31'd0, bus_if.dmem_req_o}, 32'd0);
    end
    bus_if.valid_i = 1'b0;
    do_reset(0);

    // HALT instruction.
    send(8'h00, 1'b1, 32'h0, 32'h0, 32'h0, 8'h0F, 8'h0F, 0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("hlt_stall", {31'd0, bus_if.stall_o}, 32'd1);
    do_reset(0);

    // Bus error on a load.
    send(8'h05, 1'b1, 32'h300, 32'h0, 32'h0, 8'h0F, 8'h06, 2, 32'h1111, 1'b1);
    @(posedge clk);
    #1;
    chk("err_stall", {31'd0, bus_if.stall_o}, 32'd1);
    do_reset(0);

    // Normal operation resumes after reset.
    send(8'h05, 1'b1, 32'h40, 32'h0, 32'h0, 8'h0F, 8'h07, 1, 32'hCAFEF00D, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
